mem_interconnect: RTL and testbench

- Parametrised memory-bus interconnect between the single common memory bus (bus arbiter output) and N memory-mapped slaves (RAM, LEDs, UART, timer, future peripherals).
- Replaces hard-wired address decode and OR'd read data with a table-driven decoder, per-slave multi-cycle ready handshake, registered read mux, bus timeout and error reporting.
- Adds wait-state support and fault capture, which the single-cycle decode scheme does not have.

---
 rtl/mem_interconnect_if.sv | 35 +++
 rtl/mem_interconnect.sv | 132 +++++++++++++
 tb/tb_mem_interconnect.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_interconnect_if.sv
// rtl/mem_interconnect_if.sv - master-side and slave-side bus signals of the memory interconnect
interface mem_interconnect_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]              address_in;
    logic                     read_in;
    logic                     write_in;
    logic [3:0]               write_mask_in;
    logic [31:0]              write_value_in;
    logic [31:0]              read_value_out;
    logic                     ready_out;
    logic                     error_out;
    logic [31:0]              fault_address_out;
    logic [NUM_SLAVES-1:0]    sel_out;
    logic [31:0]              address_out;
    logic                     read_out;
    logic [3:0]               write_mask_out;
    logic [31:0]              write_value_out;
    logic [NUM_SLAVES*32-1:0] read_value_in;
    logic [NUM_SLAVES-1:0]    ready_in;

    modport slave (
        input  address_in, read_in, write_in, write_mask_in, write_value_in,
        input  read_value_in, ready_in,
        output read_value_out, ready_out, error_out, fault_address_out,
        output sel_out, address_out, read_out, write_mask_out, write_value_out
    );

    modport master (
        output address_in, read_in, write_in, write_mask_in, write_value_in,
        output read_value_in, ready_in,
        input  read_value_out, ready_out, error_out, fault_address_out,
        input  sel_out, address_out, read_out, write_mask_out, write_value_out
    );
endinterface

// File: rtl/mem_interconnect.sv
// rtl/mem_interconnect.sv - table-decoded memory bus interconnect with wait states, timeout and fault capture
module mem_interconnect #(
    parameter int                      NUM_SLAVES  = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASES = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASKS = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_0000},
    parameter int                      TIMEOUT     = 255,
    parameter logic [31:0]             ERR_VALUE   = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_interconnect_if.slave    bus
);
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   fault_q, fault_d;
    logic [31:0]   addr_q, addr_d;

    logic          req;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          in_wait;

    assign req = bus.read_in | bus.write_in;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.address_in & SLAVE_MASKS[32*i +: 32]) == SLAVE_BASES[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_ready = bus.ready_in[i];
                sel_rdata = bus.read_value_in[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            fault_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = bus.address_in;
                    if (hit) begin
                        idx_d   = hit_idx;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ERR_VALUE;
                        fault_d = bus.address_in;
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                // A slave answering on the last allowed cycle still beats the timeout.
                if (sel_ready) begin
                    err_d   = 1'b0;
                    rdata_d = bus.write_in ? 32'h0 : sel_rdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_VALUE;
                    fault_d = addr_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_wait               = (state_q == WAIT);
    assign bus.sel_out           = in_wait ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign bus.address_out       = in_wait ? bus.address_in : 32'h0;
    assign bus.read_out          = in_wait & bus.read_in;
    assign bus.write_mask_out    = (in_wait & bus.write_in) ? bus.write_mask_in : 4'h0;
    assign bus.write_value_out   = in_wait ? bus.write_value_in : 32'h0;
    assign bus.ready_out         = (state_q == RESP);
    assign bus.error_out         = (state_q == RESP) & err_q;
    assign bus.read_value_out    = rdata_q;
    assign bus.fault_address_out = fault_q;
endmodule

// File: tb/tb_mem_interconnect.sv
// tb/tb_mem_interconnect.sv - scoreboard bench for mem_interconnect with behavioural slaves and random traffic
module tb_mem_interconnect;
    localparam int               N    = 4;
    localparam int               TO   = 255;
    localparam logic [31:0]      ERRV = 32'hDEAD_BEEF;
    localparam logic [N*32-1:0]  BASES = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [N*32-1:0]  MASKS = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_0000};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_interconnect_if #(.NUM_SLAVES(N)) bus();

    mem_interconnect #(
        .NUM_SLAVES(N), .SLAVE_BASES(BASES), .SLAVE_MASKS(MASKS),
        .TIMEOUT(TO), .ERR_VALUE(ERRV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] base_tab [N] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    logic [31:0] mask_tab [N] = '{32'hFFFF_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    typedef struct {
        logic [31:0] data;
        bit          err;
        logic [31:0] fault;
        int          lat;
        int          start;
        int          slave;
        int          sel_cycles;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] exp_fault = 32'h0;

    int          slave_wait [N];
    logic [31:0] slave_data [N];
    int          scnt [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Each slave answers after slave_wait[i] cycles of being selected.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            scnt[i] <= (bus.sel_out[i] && !bus.ready_in[i]) ? scnt[i] + 1 : 0;
    end

    always_comb begin
        bus.ready_in      = '0;
        bus.read_value_in = '0;
        for (int i = 0; i < N; i++) begin
            bus.ready_in[i]             = bus.sel_out[i] && (scnt[i] == slave_wait[i]);
            bus.read_value_in[32*i +: 32] = slave_data[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & mask_tab[i]) == base_tab[i]) return i;
        return -1;
    endfunction

    task automatic issue(input logic [31:0] a, input bit wr, input logic [3:0] m,
                         input logic [31:0] wd, input int waits, input logic [31:0] sdata);
        exp_t e;
        int   s;
        bit   seen;
        s = decode(a);
        @(posedge clk);
        #1;
        if (s >= 0) begin
            slave_wait[s] = waits;
            slave_data[s] = sdata;
        end
        bus.address_in     = a;
        bus.read_in        = !wr;
        bus.write_in       = wr;
        bus.write_mask_in  = m;
        bus.write_value_in = wd;
        e.start = cyc;
        e.slave = s;
        if (s < 0) begin
            e.err = 1; e.data = ERRV; e.lat = 1; e.sel_cycles = 0;
        end else if (waits < TO) begin
            e.err = 0; e.data = wr ? 32'h0 : sdata; e.lat = waits + 2; e.sel_cycles = waits + 1;
        end else begin
            e.err = 1; e.data = ERRV; e.lat = TO + 1; e.sel_cycles = TO;
        end
        if (e.err) exp_fault = a;
        e.fault = exp_fault;
        q.push_back(e);
        seen = 0;
        for (int k = 0; k < TO + 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus.ready_out;
        end
        if (!seen) begin
            chk("completion_wait", 32'h0, 32'h1);
            q.delete();
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.read_in  = 1'b0;
        bus.write_in = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    int          sel_cnt = 0;
    bit          bad_sel = 0;
    bit          bad_bus = 0;
    logic [N-1:0] want_sel;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                sel_cnt = 0; bad_sel = 0; bad_bus = 0;
            end else begin
                if (bus.sel_out != '0) begin
                    sel_cnt++;
                    if (!$onehot(bus.sel_out)) bad_sel = 1;
                    if (q.size() > 0 && q[0].slave >= 0) begin
                        want_sel = '0;
                        want_sel[q[0].slave] = 1'b1;
                        if (bus.sel_out != want_sel) bad_sel = 1;
                    end
                    if (bus.address_out !== bus.address_in || bus.read_out !== bus.read_in ||
                        bus.write_value_out !== bus.write_value_in ||
                        bus.write_mask_out !== (bus.write_in ? bus.write_mask_in : 4'h0)) bad_bus = 1;
                end else if (bus.address_out != 0 || bus.read_out || bus.write_mask_out != 0 ||
                             bus.write_value_out != 0) begin
                    bad_bus = 1;
                end
                if (bus.ready_out) begin
                    if (q.size() == 0) begin
                        chk("spurious_ready", 32'h1, 32'h0);
                    end else begin
                        mon_e = q.pop_front();
                        chk("read_value", bus.read_value_out, mon_e.data);
                        chk("error", 32'(bus.error_out), 32'(mon_e.err));
                        chk("fault_address", bus.fault_address_out, mon_e.fault);
                        chk("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
                        chk("sel_cycles", 32'(sel_cnt), 32'(mon_e.sel_cycles));
                        chk("sel_onehot", 32'(bad_sel), 32'h0);
                        chk("slave_bus", 32'(bad_bus), 32'h0);
                    end
                    sel_cnt = 0; bad_sel = 0; bad_bus = 0;
                end
            end
        end
    end

    initial begin
        int s;
        int w;
        logic [31:0] a;
        for (int i = 0; i < N; i++) begin
            slave_wait[i] = 0;
            slave_data[i] = 32'h0;
        end
        bus.address_in = 0; bus.read_in = 0; bus.write_in = 0;
        bus.write_mask_in = 0; bus.write_value_in = 0;
        #12;
        chk("reset_ready", 32'(bus.ready_out), 32'h0);
        chk("reset_error", 32'(bus.error_out), 32'h0);
        chk("reset_read_value", bus.read_value_out, 32'h0);
        chk("reset_fault", bus.fault_address_out, 32'h0);
        chk("reset_sel", 32'(bus.sel_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        issue(32'h0000_0010, 0, 4'h0, 32'h0, 0, 32'h1234_5678);
        idle(1);
        issue(32'h0001_0000, 1, 4'b0001, 32'h0000_00A5, 3, 32'h7777_7777);
        idle(1);
        issue(32'h0004_0000, 0, 4'h0, 32'h0, 0, 32'h0);
        idle(1);
        issue(32'h0002_0004, 0, 4'h0, 32'h0, 1000, 32'h5555_5555);
        idle(1);
        issue(32'h0002_0004, 0, 4'h0, 32'h0, TO - 1, 32'hCAFE_F00D);
        issue(32'h0000_0008, 0, 4'h0, 32'h0, 0, 32'h1111_1111);
        issue(32'h0003_000C, 0, 4'h0, 32'h0, 2, 32'h3333_3333);
        idle(2);

        @(posedge clk);
        #1;
        slave_wait[2] = 1000;
        bus.address_in = 32'h0002_0004; bus.read_in = 1; bus.write_in = 0;
        repeat (4) @(negedge clk);
        chk("sel_before_reset", 32'(bus.sel_out), 32'h4);
        #1 reset = 1'b1;
        #1;
        chk("abort_sel", 32'(bus.sel_out), 32'h0);
        chk("abort_ready", 32'(bus.ready_out), 32'h0);
        chk("abort_read_value", bus.read_value_out, 32'h0);
        chk("abort_fault", bus.fault_address_out, 32'h0);
        chk("abort_read_out", 32'(bus.read_out), 32'h0);
        bus.read_in = 0;
        exp_fault = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(bus.ready_out), 32'h0);
        end
        reset = 1'b0;
        issue(32'h0003_0004, 0, 4'h0, 32'h0, 1, 32'hBEEF_0001);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) < 2) begin
                a = $urandom();
            end else begin
                s = $urandom_range(0, N - 1);
                a = base_tab[s] + 32'($urandom_range(0, 15));
            end
            w = ($urandom_range(0, 19) == 0) ? 300 : $urandom_range(0, 4);
            issue(a, 1'($urandom_range(0, 1)), 4'($urandom()), $urandom(), w, $urandom());
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        idle(2);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
